// File: rtl/io_uart_port.sv
// rtl/io_uart_port.sv - IO-port responder with TX/RX FIFOs between the processor IO bus and rs232_uart
// Decodes DATA, STATUS, RX_COUNT and CTRL at BASE_PORT..BASE_PORT+3.
module io_uart_port #(
  parameter logic [7:0] BASE_PORT     = 8'h01,
  parameter int         TX_DEPTH_LOG2 = 4,
  parameter int         RX_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  output logic [7:0] uart_tx_data,
  output logic       uart_write_tx,
  input  logic       uart_tx_buffer_full,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_data_present,
  output logic       uart_read_rx_ack
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL_CNT = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_GAP  = 1'b1;
  localparam logic [0:0] RX_IDLE    = 1'b0;
  localparam logic [0:0] RX_ACKWAIT = 1'b1;

  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wptr, tx_rptr;
  logic [RX_DEPTH_LOG2-1:0] rx_wptr, rx_rptr;
  logic [TX_DEPTH_LOG2:0]   tx_count;
  logic [RX_DEPTH_LOG2:0]   rx_count;
  logic [0:0] tx_state, rx_state;
  logic       rx_underflow, tx_overflow;

  logic [7:0] offset;
  logic in_range, sel_data, sel_status, sel_count, sel_ctrl;
  logic wr_data, rd_data, ctrl_wr, tx_flush, rx_flush, clr_sticky;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_ovf_evt, rx_fill, rx_pop, rx_unf_evt;
  logic [7:0] status;

  assign offset     = IO_port_ID - BASE_PORT;
  assign in_range   = offset < 8'd4;
  assign sel_data   = in_range && offset[1:0] == 2'd0;
  assign sel_status = in_range && offset[1:0] == 2'd1;
  assign sel_count  = in_range && offset[1:0] == 2'd2;
  assign sel_ctrl   = in_range && offset[1:0] == 2'd3;

  assign wr_data    = IO_write_strobe && sel_data;
  assign rd_data    = IO_read_strobe && sel_data;
  assign ctrl_wr    = IO_write_strobe && sel_ctrl;
  assign clr_sticky = ctrl_wr && IO_write_data[0];
  assign rx_flush   = ctrl_wr && IO_write_data[1];
  assign tx_flush   = ctrl_wr && IO_write_data[2];

  assign tx_full  = tx_count == TX_FULL_CNT;
  assign tx_empty = tx_count == '0;
  assign rx_full  = rx_count == RX_FULL_CNT;
  assign rx_empty = rx_count == '0;

  // Flush outranks every push and pop in the same cycle.
  assign tx_push    = wr_data && !tx_full && !tx_flush;
  assign tx_ovf_evt = wr_data && tx_full;
  assign tx_pop     = tx_state == TX_IDLE && !tx_empty && !uart_tx_buffer_full && !tx_flush;
  assign rx_fill    = rx_state == RX_IDLE && uart_rx_data_present && !rx_full && !rx_flush;
  assign rx_pop     = rd_data && !rx_empty && !rx_flush;
  assign rx_unf_evt = rd_data && rx_empty;

  assign status = {3'b000, tx_empty, tx_overflow, rx_underflow, tx_full, !rx_empty};

  always_comb begin
    IO_read_data = 8'h00;
    if (IO_read_strobe) begin
      if (sel_data && !rx_empty) IO_read_data = rx_mem[rx_rptr];
      else if (sel_status)       IO_read_data = status;
      else if (sel_count)        IO_read_data = 8'(rx_count);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= IO_write_data;
    if (rx_fill) rx_mem[rx_wptr] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wptr       <= '0;
      tx_rptr       <= '0;
      tx_count      <= '0;
      tx_state      <= TX_IDLE;
      uart_write_tx <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      uart_write_tx <= tx_pop;
      if (tx_pop) uart_tx_data <= tx_mem[tx_rptr];
      tx_state <= (tx_state == TX_IDLE && tx_pop) ? TX_GAP : TX_IDLE;
      if (tx_flush) begin
        tx_wptr  <= '0;
        tx_rptr  <= '0;
        tx_count <= '0;
      end else begin
        if (tx_push) tx_wptr <= tx_wptr + 1'b1;
        if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
        tx_count <= tx_count + {{TX_DEPTH_LOG2{1'b0}}, tx_push} - {{TX_DEPTH_LOG2{1'b0}}, tx_pop};
      end
    end
  end

  // The ack trails the push by one cycle; ACKWAIT covers the UART dropping its present flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wptr          <= '0;
      rx_rptr          <= '0;
      rx_count         <= '0;
      rx_state         <= RX_IDLE;
      uart_read_rx_ack <= 1'b0;
    end else begin
      uart_read_rx_ack <= rx_fill;
      rx_state <= (rx_state == RX_IDLE && rx_fill) ? RX_ACKWAIT : RX_IDLE;
      if (rx_flush) begin
        rx_wptr  <= '0;
        rx_rptr  <= '0;
        rx_count <= '0;
      end else begin
        if (rx_fill) rx_wptr <= rx_wptr + 1'b1;
        if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        rx_count <= rx_count + {{RX_DEPTH_LOG2{1'b0}}, rx_fill} - {{RX_DEPTH_LOG2{1'b0}}, rx_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      rx_underflow <= (rx_underflow && !clr_sticky) || rx_unf_evt;
      tx_overflow  <= (tx_overflow && !clr_sticky) || tx_ovf_evt;
    end
  end

endmodule

// File: tb/tb_io_uart_port.sv
// tb/tb_io_uart_port.sv - directed/randomized bench for io_uart_port against a queue-level model
module tb_io_uart_port;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] IO_port_ID = 8'h00;
  logic [7:0] IO_write_data = 8'h00;
  logic       IO_write_strobe = 1'b0;
  logic       IO_read_strobe = 1'b0;
  logic [7:0] IO_read_data;
  logic [7:0] uart_tx_data;
  logic       uart_write_tx;
  logic       uart_tx_buffer_full = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_data_present = 1'b0;
  logic       uart_read_rx_ack;

  io_uart_port #(.BASE_PORT(8'h01), .TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset),
    .IO_port_ID(IO_port_ID), .IO_write_data(IO_write_data),
    .IO_write_strobe(IO_write_strobe), .IO_read_strobe(IO_read_strobe),
    .IO_read_data(IO_read_data),
    .uart_tx_data(uart_tx_data), .uart_write_tx(uart_write_tx),
    .uart_tx_buffer_full(uart_tx_buffer_full),
    .uart_rx_data(uart_rx_data), .uart_rx_data_present(uart_rx_data_present),
    .uart_read_rx_ack(uart_read_rx_ack)
  );

  localparam logic [7:0] P_DATA = 8'h01, P_STAT = 8'h02, P_CNT = 8'h03, P_CTRL = 8'h04;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_cnt = 0;
  logic rx_en = 1'b0;
  logic [7:0] tx_seen[$];
  int         tx_cyc[$];
  logic [7:0] rx_src[$];

  always @(posedge clk) cyc++;

  // UART side: records TX pulses, and serves RX bytes, retiring one on each ack.
  always @(negedge clk) begin
    if (uart_write_tx) begin
      tx_seen.push_back(uart_tx_data);
      tx_cyc.push_back(cyc);
    end
    if (uart_read_rx_ack) begin
      ack_cnt++;
      if (rx_src.size() > 0) void'(rx_src.pop_front());
    end
    uart_rx_data_present = rx_en && rx_src.size() > 0;
    uart_rx_data = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status_exp(input int rxn, input int txn, input bit unf, input bit ovf);
    int v;
    v = 0;
    if (rxn != 0)  v += 1;
    if (txn == 16) v += 2;
    if (unf)       v += 4;
    if (ovf)       v += 8;
    if (txn == 0)  v += 16;
    return 8'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d);
    IO_port_ID = p;
    IO_write_data = d;
    IO_write_strobe = 1'b1;
    tick();
    IO_write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] p, output logic [7:0] d);
    IO_port_ID = p;
    IO_read_strobe = 1'b1;
    #1 d = IO_read_data;
    @(posedge clk);
    #1 IO_read_strobe = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int limit);
    for (int i = 0; i < limit && tx_seen.size() < n; i++) tick();
  endtask

  task automatic wait_ack(input int n, input int limit);
    for (int i = 0; i < limit && ack_cnt < n; i++) tick();
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] b;
    int n;

    // Reset
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    check("rst_write_tx", uart_write_tx, 0);
    check("rst_rx_ack", uart_read_rx_ack, 0);
    check("rst_tx_data", uart_tx_data, 0);
    check("rst_read_data", IO_read_data, 0);
    io_read(P_STAT, r);
    check("rst_status", r, status_exp(0, 0, 0, 0));

    // TX burst
    exp_tx = '{8'h41, 8'h42, 8'h43};
    foreach (exp_tx[i]) io_write(P_DATA, exp_tx[i]);
    wait_tx(3, 30);
    repeat (4) tick();
    check("burst_count", tx_seen.size(), 3);
    for (int i = 0; i < 3 && i < tx_seen.size(); i++) check("burst_byte", tx_seen[i], exp_tx[i]);
    for (int i = 1; i < tx_cyc.size(); i++) check("burst_spacing", (tx_cyc[i] - tx_cyc[i-1]) >= 2, 1);
    io_read(P_STAT, r);
    check("burst_status", r, status_exp(0, 0, 0, 0));
    tx_seen.delete(); tx_cyc.delete(); exp_tx.delete();

    // TX overflow under UART backpressure
    uart_tx_buffer_full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) exp_tx.push_back(b);
      io_write(P_DATA, b);
    end
    repeat (3) tick();
    check("ovf_no_drain", tx_seen.size(), 0);
    io_read(P_STAT, r);
    check("ovf_status", r, status_exp(0, 16, 0, 1));
    uart_tx_buffer_full = 1'b0;
    wait_tx(16, 80);
    repeat (6) tick();
    check("ovf_drain_count", tx_seen.size(), 16);
    for (int i = 0; i < 16 && i < tx_seen.size(); i++) check("ovf_drain_byte", tx_seen[i], exp_tx[i]);
    io_read(P_STAT, r);
    check("ovf_status_sticky", r, status_exp(0, 0, 0, 1));
    io_write(P_CTRL, 8'h01);
    io_read(P_STAT, r);
    check("ovf_cleared", r, status_exp(0, 0, 0, 0));
    tx_seen.delete(); tx_cyc.delete(); exp_tx.delete();

    // RX fill to full, then backpressure
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      rx_src.push_back(b);
      exp_rx.push_back(b);
    end
    rx_en = 1'b1;
    wait_ack(16, 80);
    repeat (6) tick();
    check("rx_acks_full", ack_cnt, 16);
    io_read(P_CNT, r);
    check("rx_count_full", r, 16);
    io_read(P_STAT, r);
    check("rx_status_full", r, status_exp(16, 0, 0, 0));
    io_read(P_DATA, r);
    check("rx_first_byte", r, exp_rx.pop_front());
    wait_ack(17, 4);
    check("rx_17th_acked", ack_cnt, 17);
    for (int i = 0; i < 16; i++) begin
      io_read(P_DATA, r);
      check("rx_byte", r, exp_rx.pop_front());
    end
    io_read(P_CNT, r);
    check("rx_count_drained", r, 0);

    // Underflow
    io_read(P_DATA, r);
    check("unf_data", r, 0);
    io_read(P_STAT, r);
    check("unf_status", r, status_exp(0, 0, 1, 0));
    io_read(P_CNT, r);
    check("unf_count", r, 0);
    io_write(P_CTRL, 8'h01);
    io_read(P_STAT, r);
    check("unf_cleared", r, status_exp(0, 0, 0, 0));

    // RX flush
    for (int i = 0; i < 5; i++) rx_src.push_back(8'($urandom));
    wait_ack(22, 40);
    repeat (3) tick();
    io_read(P_CNT, r);
    check("flush_rx_pre", r, 5);
    io_write(P_CTRL, 8'h02);
    io_read(P_CNT, r);
    check("flush_rx_post", r, 0);
    rx_en = 1'b0;

    // Reset while TX drains
    for (int i = 0; i < 6; i++) io_write(P_DATA, 8'($urandom));
    wait_tx(2, 20);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n = tx_seen.size();
    check("rst_mid_pulses_seen", n >= 2, 1);
    repeat (20) tick();
    check("rst_mid_no_more_tx", tx_seen.size(), n);
    io_read(P_STAT, r);
    check("rst_mid_status", r, status_exp(0, 0, 0, 0));
    io_read(P_CNT, r);
    check("rst_mid_rx_count", r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
